// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// No logic; no latency; no backpressure.
// State encoding, default width and the saturated overflow quotient.
package div_pkg;

    localparam int DW_DEF = 8;

    // Quotient reported on overflow or divide-by-zero.
    localparam logic [DW_DEF-1:0] OVF_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
// Latency 0 (pure combinational).
// No backpressure; the caller decides when to register the result.
module div_step
    import div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0]   rem,
    input  logic          nbit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_nxt,
    output logic          qbit
);

    logic [DW:0] shifted;
    logic [DW:0] trial;

    assign shifted = {rem[DW-1:0], nbit};
    assign trial   = shifted - {1'b0, divisor};

    // A set rem[DW] means the true partial remainder exceeds 2^DW, so the
    // subtraction always succeeds; it stays clear in normal operation.
    assign qbit    = ~trial[DW] | rem[DW];
    assign rem_nxt = qbit ? trial : shifted;

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential 2*DW / DW unsigned restoring divider, one quotient bit per cycle.
// Latency DW+1 cycles from accept (1 cycle for overflow or divide-by-zero).
// Result held in DONE until out_ready; no new operand is taken until then.
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     quotient,
    output logic [DW-1:0]     remainder,
    output logic              ovf,
    output logic              dz
);

    localparam int CW = $clog2(DW);

    state_t          state;
    state_t          state_nxt;
    logic [DW:0]     rem;
    logic [DW:0]     rem_nxt;
    logic [DW-1:0]   shreg;
    logic [DW-1:0]   dvs;
    logic [CW-1:0]   cnt;
    logic            qbit;
    logic [DW-1:0]   hi;
    logic            accept;
    logic            div_zero;
    logic            too_big;

    assign hi       = dividend[2*DW-1:DW];
    assign accept   = in_valid && (state == IDLE);
    assign div_zero = (divisor == '0);
    assign too_big  = (hi >= divisor);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_step #(.DW(DW)) u_step (
        .rem     (rem),
        .nbit    (shreg[DW-1]),
        .divisor (dvs),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (div_zero || too_big) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            shreg     <= '0;
            dvs       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else if (accept) begin
            dvs <= divisor;
            if (div_zero) begin
                quotient  <= {DW{1'b1}};
                remainder <= '0;
                ovf       <= 1'b1;
                dz        <= 1'b1;
            end else if (too_big) begin
                quotient  <= {DW{1'b1}};
                remainder <= '0;
                ovf       <= 1'b1;
                dz        <= 1'b0;
            end else begin
                rem   <= {1'b0, hi};
                shreg <= dividend[DW-1:0];
                cnt   <= CW'(DW - 1);
                ovf   <= 1'b0;
                dz    <= 1'b0;
            end
        end else if (state == CALC) begin
            // Quotient bits fill the low end as dividend bits leave the top.
            rem   <= rem_nxt;
            shreg <= {shreg[DW-2:0], qbit};
            cnt   <= cnt - CW'(1);
            if (cnt == '0) begin
                quotient  <= {shreg[DW-2:0], qbit};
                remainder <= rem_nxt[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: vector table, corner sequences, random pairs.
module tb_div_16x8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;

    always #5 clk = ~clk;

    div_16x8_seq #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    vec_t vt[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t e;
        e.dd = dd;
        e.dv = dv;
        if (dv == 8'h00) begin
            e.q = 8'hFF; e.r = 8'h00; e.ovf = 1'b1; e.dz = 1'b1;
        end else if (dd[15:8] >= dv) begin
            e.q = 8'hFF; e.r = 8'h00; e.ovf = 1'b1; e.dz = 1'b0;
        end else begin
            e.q = 8'(dd / {8'h00, dv});
            e.r = 8'(dd % {8'h00, dv});
            e.ovf = 1'b0; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive one operand pair, record its expectation, and measure latency
    // counting the accept edge as cycle 1.
    task automatic issue(input logic [15:0] dd, input logic [7:0] dv, input exp_t e, output int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        if (in_ready) sb.push_back(e);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        exp_t e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        vt[0] = '{16'h00C8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0, 9};
        vt[1] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
        vt[2] = '{16'h1234, 8'h12, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
        vt[3] = '{16'h0050, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1};
        vt[4] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 9};
        vt[5] = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 9};
        vt[6] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
        vt[7] = '{16'h0100, 8'h02, 8'h80, 8'h00, 1'b0, 1'b0, 9};
        vt[8] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
        vt[9] = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1};

        fork
            begin : monitor
                exp_t m;
                forever begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_output", 32'(out_valid), 32'd0);
                        end else begin
                            m = sb.pop_front();
                            chk("quotient", 32'(quotient), 32'(m.q));
                            chk("remainder", 32'(remainder), 32'(m.r));
                            chk("ovf", 32'(ovf), 32'(m.ovf));
                            chk("dz", 32'(dz), 32'(m.dz));
                            if (!m.ovf) begin
                                chk("identity", 32'(quotient) * 32'(m.dv) + 32'(remainder), 32'(m.dd));
                                chk("rem_lt_div", 32'(remainder < m.dv), 32'd1);
                            end
                        end
                    end
                end
            end
        join_none

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            e = '{vt[i].dd, vt[i].dv, vt[i].q, vt[i].r, vt[i].ovf, vt[i].dz};
            issue(vt[i].dd, vt[i].dv, e, lat);
            chk($sformatf("latency_vec%0d", i), 32'(lat), 32'(vt[i].lat));
            drain();
        end

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(16'h0064, 8'h0A, '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0}, lat);
        chk("bp_latency", 32'(lat), 32'd9);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_quotient", 32'(quotient), 32'h0A);
            chk("bp_remainder", 32'(remainder), 32'h00);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset in the 4th CALC cycle discards the operation.
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = 16'h00C8;
        divisor  = 8'h07;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midcalc_rst_quotient", 32'(quotient), 32'd0);
        chk("midcalc_rst_remainder", 32'(remainder), 32'd0);
        chk("midcalc_rst_ovf", 32'(ovf), 32'd0);
        chk("midcalc_rst_dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'h00FF, 8'h10, '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0}, lat);
        chk("post_rst_latency", 32'(lat), 32'd9);
        drain();

        for (int n = 0; n < 1500; n++) begin
            logic [7:0]  dv;
            logic [7:0]  hi;
            logic [7:0]  lo;
            dv = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, 32'(dv) - 1));
            lo = 8'($urandom_range(0, 255));
            e  = model({hi, lo}, dv);
            issue({hi, lo}, dv, e, lat);
            chk("rand_latency", 32'(lat), 32'd9);
            drain();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
